// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN accumulate/requantize path.
// Provides clog2, default width constants and saturation bounds.
package cnn_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int tree_w(input int dw, input int n);
        return prod_w(dw) + clog2(n);
    endfunction

    function automatic int acc_w(input int dw, input int n, input int g);
        return tree_w(dw, n) + g;
    endfunction

    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam int DATA_W_DEF  = 16;
    localparam int INPUT_N_DEF = 6;
    localparam int GUARD_DEF   = 8;
    localparam int PROD_W_DEF  = prod_w(DATA_W_DEF);
    localparam int TREE_W_DEF  = tree_w(DATA_W_DEF, INPUT_N_DEF);
    localparam int ACC_W_DEF   = acc_w(DATA_W_DEF, INPUT_N_DEF, GUARD_DEF);

endpackage

// File: rtl/add_tree_pipe.sv
// Registered pairwise adder tree with valid/last/bias sideband delay.
// Ports: clk, rst, in_valid/in_last/in_data/in_bias -> out_valid/out_last/out_sum/out_bias.
module add_tree_pipe
    import cnn_pkg::*;
#(
    parameter  int N  = 6,
    parameter  int IW = 32,
    parameter  int BW = 16,
    localparam int OW = IW + clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [N*IW-1:0]   in_data,
    input  logic [BW-1:0]     in_bias,
    output logic              out_valid,
    output logic              out_last,
    output logic [OW-1:0]     out_sum,
    output logic [BW-1:0]     out_bias
);

    localparam int S = clog2(N);
    localparam int P = 1 << S;

    // Leaves are sign-extended to the final width and zero-padded to P.
    logic signed [OW-1:0] leaf [P];

    always_comb begin
        for (int i = 0; i < P; i++) leaf[i] = '0;
        for (int i = 0; i < N; i++) begin
            leaf[i] = OW'($signed(in_data[IW*i +: IW]));
        end
    end

    if (S == 0) begin : g_pass
        assign out_sum   = leaf[0];
        assign out_valid = in_valid;
        assign out_last  = in_valid && in_last;
        assign out_bias  = in_bias;
    end else begin : g_tree
        logic signed [OW-1:0] tree_d [S][P];
        logic signed [OW-1:0] tree_q [S][P];
        logic [BW-1:0]        bias_d [S];
        logic [BW-1:0]        bias_q [S];
        logic [S-1:0]         vld_d, vld_q;
        logic [S-1:0]         lst_d, lst_q;

        always_comb begin
            for (int l = 0; l < S; l++) begin
                for (int j = 0; j < P; j++) tree_d[l][j] = '0;
            end
            for (int j = 0; j < P / 2; j++) begin
                tree_d[0][j] = leaf[2*j] + leaf[2*j+1];
            end
            for (int l = 1; l < S; l++) begin
                for (int j = 0; j < (P >> (l + 1)); j++) begin
                    tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
                end
            end
            vld_d[0]  = in_valid;
            lst_d[0]  = in_valid && in_last;
            bias_d[0] = in_bias;
            for (int l = 1; l < S; l++) begin
                vld_d[l]  = vld_q[l-1];
                lst_d[l]  = lst_q[l-1];
                bias_d[l] = bias_q[l-1];
            end
        end

        always_ff @(posedge clk) begin
            tree_q <= tree_d;
            bias_q <= bias_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
                lst_q <= '0;
            end else begin
                vld_q <= vld_d;
                lst_q <= lst_d;
            end
        end

        assign out_sum   = tree_q[S-1][0];
        assign out_valid = vld_q[S-1];
        assign out_last  = lst_q[S-1];
        assign out_bias  = bias_q[S-1];
    end

endmodule

// File: rtl/acc_tree_quant.sv
// Adder tree + group accumulator + bias add + requantize to DATA_WIDTH.
// Ports: clk, rst, in_valid, in_last, product_data, bias -> out_valid, out_data.
module acc_tree_quant
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int INPUT_NUM  = 6,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_GUARD  = 8,
    parameter int RELU_EN    = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic                              in_last,
    input  logic [DATA_WIDTH*INPUT_NUM*2-1:0] product_data,
    input  logic [DATA_WIDTH-1:0]             bias,
    output logic                              out_valid,
    output logic [DATA_WIDTH-1:0]             out_data
);

    localparam int PW    = prod_w(DATA_WIDTH);
    localparam int TW    = tree_w(DATA_WIDTH, INPUT_NUM);
    localparam int ACC_W = acc_w(DATA_WIDTH, INPUT_NUM, ACC_GUARD);
    localparam int QW    = ACC_W + 1;

    localparam logic signed [QW-1:0] SAT_HI = QW'(sat_hi(DATA_WIDTH));
    localparam logic signed [QW-1:0] SAT_LO = QW'(sat_lo(DATA_WIDTH));

    logic                  t_valid, t_last;
    logic [TW-1:0]         t_sum;
    logic [DATA_WIDTH-1:0] t_bias;

    add_tree_pipe #(
        .N  (INPUT_NUM),
        .IW (PW),
        .BW (DATA_WIDTH)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (product_data),
        .in_bias   (bias),
        .out_valid (t_valid),
        .out_last  (t_last),
        .out_sum   (t_sum),
        .out_bias  (t_bias)
    );

    logic signed [ACC_W-1:0]      acc_d, acc_q, grp_d, grp_q, acc_sum;
    logic                         first_d, first_q, gvld_d, gvld_q;
    logic [DATA_WIDTH-1:0]        gbias_d, gbias_q;
    logic                         out_valid_d, out_valid_q;
    logic [DATA_WIDTH-1:0]        out_data_d, out_data_q;
    logic signed [QW-1:0]         biased, r;
    logic signed [DATA_WIDTH-1:0] qv;

    always_comb begin
        acc_sum = (first_q ? '0 : acc_q) + ACC_W'($signed(t_sum));
        acc_d   = acc_q;
        first_d = first_q;
        grp_d   = grp_q;
        gbias_d = gbias_q;
        gvld_d  = 1'b0;
        if (t_valid) begin
            acc_d   = acc_sum;
            first_d = t_last;
            if (t_last) begin
                gvld_d  = 1'b1;
                grp_d   = acc_sum;
                gbias_d = t_bias;
            end
        end
    end

    // Bias is aligned to the product's 2*FRAC_BITS scale before the floor shift.
    always_comb begin
        biased = QW'(grp_q) + (QW'($signed(gbias_q)) <<< FRAC_BITS);
        r      = biased >>> FRAC_BITS;
        if (r > SAT_HI)      qv = SAT_HI[DATA_WIDTH-1:0];
        else if (r < SAT_LO) qv = SAT_LO[DATA_WIDTH-1:0];
        else                 qv = r[DATA_WIDTH-1:0];
        if (RELU_EN != 0 && qv < 0) qv = '0;
        out_valid_d = gvld_q;
        out_data_d  = gvld_q ? qv : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            grp_q       <= '0;
            gbias_q     <= '0;
            gvld_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            first_q     <= first_d;
            grp_q       <= grp_d;
            gbias_q     <= gbias_d;
            gvld_q      <= gvld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_acc_tree_quant.sv
// Scoreboard bench for acc_tree_quant: two DUTs (RELU off/on) share stimulus.
// A group-level reference model pushes expected results; monitors pop and compare.
module tb_acc_tree_quant;

    localparam int DW  = 16;
    localparam int N   = 6;
    localparam int FB  = 8;
    localparam int LAT = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_last;
    logic [DW*N*2-1:0] pd;
    logic [DW-1:0]     bias;
    logic              ov0, ov1;
    logic [DW-1:0]     od0, od1;

    always #5 clk = ~clk;

    acc_tree_quant #(.DATA_WIDTH(DW), .INPUT_NUM(N), .FRAC_BITS(FB),
                     .ACC_GUARD(8), .RELU_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .product_data(pd), .bias(bias), .out_valid(ov0), .out_data(od0));

    acc_tree_quant #(.DATA_WIDTH(DW), .INPUT_NUM(N), .FRAC_BITS(FB),
                     .ACC_GUARD(8), .RELU_EN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .product_data(pd), .bias(bias), .out_valid(ov1), .out_data(od1));

    typedef struct {
        longint data;
        int     cyc;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    longint grp_sum = 0;
    longint prod[N];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint quant(input longint s, input longint b, input bit relu);
        longint r;
        r = (s + b * 256) >>> FB;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    task automatic set_all(input longint v);
        for (int i = 0; i < N; i++) prod[i] = v;
    endtask

    task automatic beat(input bit v, input bit l, input longint b);
        exp_t e;
        in_valid = v;
        in_last  = l;
        bias     = DW'(b);
        for (int i = 0; i < N; i++) pd[32*i +: 32] = 32'(prod[i]);
        if (v) begin
            for (int i = 0; i < N; i++) grp_sum += prod[i];
            if (l) begin
                e.cyc  = cyc;
                e.data = quant(grp_sum, b, 1'b0);
                q0.push_back(e);
                e.data = quant(grp_sum, b, 1'b1);
                q1.push_back(e);
                grp_sum = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        q0.delete();
        q1.delete();
        grp_sum = 0;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ov0) begin
            if (q0.size() == 0) chk("unexpected_pulse0", 1, 0);
            else begin
                e = q0.pop_front();
                chk("data0", longint'($signed(od0)), e.data);
                chk("latency0", longint'(cyc - e.cyc), LAT);
            end
        end
        if (ov1) begin
            if (q1.size() == 0) chk("unexpected_pulse1", 1, 0);
            else begin
                e = q1.pop_front();
                chk("data1", longint'($signed(od1)), e.data);
                chk("latency1", longint'(cyc - e.cyc), LAT);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        pd       = '0;
        bias     = '0;
        set_all(0);
        do_reset(3);
        chk("reset_valid0", longint'(ov0), 0);
        chk("reset_data0", longint'(od0), 0);
        chk("reset_valid1", longint'(ov1), 0);
        chk("reset_data1", longint'(od1), 0);

        // single-beat group
        set_all(65536);
        beat(1, 1, 0);
        idle(8);
        // three-beat group with bias on last beat
        beat(1, 0, 0);
        beat(1, 0, 0);
        beat(1, 1, 256);
        idle(8);
        // saturation both ways
        set_all(longint'(1) <<< 30);
        beat(1, 1, 0);
        set_all(-(longint'(1) <<< 30));
        beat(1, 1, 0);
        idle(8);
        // back-to-back groups
        set_all(65536);
        beat(1, 1, 0);
        set_all(131072);
        beat(1, 1, -256);
        idle(8);
        // reset mid-group, including a last beat still in the pipe
        set_all(65536);
        beat(1, 1, 0);
        beat(1, 0, 0);
        beat(1, 0, 0);
        do_reset(1);
        beat(1, 1, 0);
        idle(8);
        // negative result: RELU off gives -1536, on gives 0
        set_all(-65536);
        beat(1, 1, 0);
        idle(8);
        // in_last without in_valid is ignored
        set_all(65536);
        beat(1, 0, 0);
        beat(0, 1, 0);
        beat(1, 1, 0);
        idle(8);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            bit v, l;
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)
                    prod[i] = longint'($signed($urandom()));
                else
                    prod[i] = longint'($urandom_range(0, 262143)) - 131072;
            end
            beat(v, l, longint'($signed(16'($urandom()))));
        end
        beat(1, 1, 0);
        idle(12);

        chk("drain0", longint'(q0.size()), 0);
        chk("drain1", longint'(q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
